data_mem_bridge: RTL and testbench

//  Sits between the load/store unit and the data-memory port. Turns the LSU's single-cycle access
//  (addr, write-valid, low-aligned wdata, rdata) into a valid/ready request plus response transaction.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_steer.sv | 47 ++++
 rtl/data_mem_bridge.sv | 172 +++++++++++++++++
 tb/tb_data_mem_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the LSU-to-data-memory bridge:
// access sizes, bridge FSM states and the default response timeout.
package mem_pkg;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Req  = 2'd1,
    Resp = 2'd2,
    Done = 2'd3
  } bridge_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: strobes, replicated store data, shifted load data, alignment.
// Ports: i_off/i_size/i_wdata/i_rdata in; o_wstrb/o_wdata/o_rdata/o_misaligned out.
module mem_lane_steer
  import mem_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] i_off,
  input  logic [1:0]      i_size,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [NB-1:0]   o_wstrb,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned
);

  logic [NB-1:0] base;

  always_comb begin
    base         = '0;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    unique case (i_size)
      MemByte: begin
        base    = NB'(1);
        o_wdata = {NB{i_wdata[7:0]}};
      end
      MemHalf: begin
        base         = NB'(3);
        o_wdata      = {(NB/2){i_wdata[15:0]}};
        o_misaligned = i_off[0];
      end
      // reserved encoding 2'b11 behaves as a word
      default: begin
        base         = NB'(4'hF);
        o_wdata      = {(NB/4){i_wdata[31:0]}};
        o_misaligned = |i_off[1:0];
      end
    endcase
    o_wstrb = base << i_off;
    o_rdata = i_rdata >> {i_off, 3'b000};
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Converts single-cycle LSU accesses into valid/ready memory transactions.
// Ports: i_lsu_* request, o_lsu_rdata/o_stall/o_misaligned/o_access_fault, o_mem_req_* / i_mem_rsp_*.
module data_mem_bridge
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lsu_wvalid,
  input  logic              i_lsu_rvalid,
  input  logic [1:0]        i_lsu_size,
  input  logic [XLEN-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  output logic [XLEN-1:0]   o_lsu_rdata,
  output logic              o_stall,
  output logic              o_misaligned,
  output logic              o_access_fault,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [XLEN-1:0]   o_mem_req_addr,
  output logic [XLEN-1:0]   o_mem_req_wdata,
  output logic [XLEN/8-1:0] o_mem_req_wstrb,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rsp_rdata,
  input  logic              i_mem_rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CntLast = CNTW'(TIMEOUT - 1);

  bridge_state_e   state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [NB-1:0]   wstrb_q, wstrb_d;
  logic [OFFW-1:0] off_q, off_d;
  logic            we_q, we_d;
  logic            fault_q, fault_d;

  logic            lsu_req;
  logic [OFFW-1:0] st_off;
  logic [NB-1:0]   st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] st_rdata;
  logic            st_mis;

  // an LSU request seen during reset must not leak onto the outputs
  assign lsu_req = (i_lsu_wvalid | i_lsu_rvalid) & ~i_rst;

  // live LSU offset while idle, captured offset once the access is in flight
  assign st_off = (state_q == Idle) ? i_lsu_addr[OFFW-1:0] : off_q;

  mem_lane_steer #(
    .XLEN (XLEN)
  ) u_steer (
    .i_off        (st_off),
    .i_size       (i_lsu_size),
    .i_wdata      (i_lsu_wdata),
    .i_rdata      (i_mem_rsp_rdata),
    .o_wstrb      (st_wstrb),
    .o_wdata      (st_wdata),
    .o_rdata      (st_rdata),
    .o_misaligned (st_mis)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= Idle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wstrb_q <= wstrb_d;
      off_q   <= off_d;
      we_q    <= we_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    wstrb_d         = wstrb_q;
    off_d           = off_q;
    we_d            = we_q;
    fault_d         = fault_q;
    o_stall         = 1'b0;
    o_misaligned    = 1'b0;
    o_mem_req_valid = 1'b0;
    unique case (state_q)
      Idle: begin
        if (lsu_req) begin
          if (st_mis) begin
            o_misaligned = 1'b1;
          end else begin
            o_stall = 1'b1;
            state_d = Req;
            // store wins when both request lines are high
            we_d    = i_lsu_wvalid;
            addr_d  = {i_lsu_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            off_d   = i_lsu_addr[OFFW-1:0];
            wstrb_d = i_lsu_wvalid ? st_wstrb : '0;
            wdata_d = i_lsu_wvalid ? st_wdata : '0;
            rdata_d = '0;
            fault_d = 1'b0;
          end
        end
      end
      Req: begin
        o_stall         = 1'b1;
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          state_d = Resp;
          cnt_d   = '0;
        end
      end
      Resp: begin
        o_stall = 1'b1;
        if (i_mem_rsp_valid) begin
          rdata_d = i_mem_rsp_err ? '0 : st_rdata;
          fault_d = i_mem_rsp_err;
          state_d = Done;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = Done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      Done: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  assign o_mem_req_we    = we_q;
  assign o_mem_req_addr  = addr_q;
  assign o_mem_req_wdata = wdata_q;
  assign o_mem_req_wstrb = wstrb_q;
  assign o_lsu_rdata     = (state_q == Done) ? rdata_q : '0;
  assign o_access_fault  = (state_q == Done) & fault_q;

  a_one_dir : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_lsu_wvalid && i_lsu_rvalid));

  a_size_ok : assert property (@(posedge i_clk) disable iff (i_rst)
    !((i_lsu_wvalid || i_lsu_rvalid) && i_lsu_size == 2'b11));

endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomised self-checking bench for data_mem_bridge against a byte-level memory model.
// Directed scenarios first, then random loads/stores with random handshake delays.
module tb_data_mem_bridge;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_lsu_wvalid, i_lsu_rvalid;
  logic [1:0]  i_lsu_size;
  logic [31:0] i_lsu_addr, i_lsu_wdata;
  logic [31:0] o_lsu_rdata;
  logic        o_stall, o_misaligned, o_access_fault;
  logic        o_mem_req_valid, i_mem_req_ready, o_mem_req_we;
  logic [31:0] o_mem_req_addr, o_mem_req_wdata;
  logic [3:0]  o_mem_req_wstrb;
  logic        i_mem_rsp_valid, i_mem_rsp_err;
  logic [31:0] i_mem_rsp_rdata;

  always #5 clk = ~clk;

  data_mem_bridge #(
    .XLEN    (XLEN),
    .TIMEOUT (TO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_lsu_wvalid    (i_lsu_wvalid),
    .i_lsu_rvalid    (i_lsu_rvalid),
    .i_lsu_size      (i_lsu_size),
    .i_lsu_addr      (i_lsu_addr),
    .i_lsu_wdata     (i_lsu_wdata),
    .o_lsu_rdata     (o_lsu_rdata),
    .o_stall         (o_stall),
    .o_misaligned    (o_misaligned),
    .o_access_fault  (o_access_fault),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_we    (o_mem_req_we),
    .o_mem_req_addr  (o_mem_req_addr),
    .o_mem_req_wdata (o_mem_req_wdata),
    .o_mem_req_wstrb (o_mem_req_wstrb),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_rdata (i_mem_rsp_rdata),
    .i_mem_rsp_err   (i_mem_rsp_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference: 64-byte window as bytes; device: same window as words
  logic [7:0]  ref_b [0:63];
  logic [31:0] dev   [0:15];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [31:0] a);
    int n;
    logic [3:0] m;
    n = 1 << sz;
    m = 4'((1 << n) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] repl(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ld_exp(input logic [31:0] a);
    int base, off;
    logic [31:0] r;
    base = int'(a[5:2]) * 4;
    off  = int'(a[1:0]);
    r    = 32'h0;
    for (int k = off; k < 4; k++)
      r = r | (32'(ref_b[base + k]) << (8 * (k - off)));
    return r;
  endfunction

  task automatic access(input bit we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int rdy, input int rsp,
                        input bit err, input bit norsp,
                        output logic [31:0] cap_a, output logic [31:0] cap_wd,
                        output logic [3:0] cap_s);
    logic [31:0] e_wd, e_rd;
    logic [3:0]  e_s;
    bit fault, hs, got, fin;
    int stalls, rq, rs, cyc, e_st, idx;
    cap_a  = '0;
    cap_wd = '0;
    cap_s  = '0;
    e_s    = we ? strb_of(sz, a) : 4'h0;
    e_wd   = repl(sz, wd);
    fault  = err || norsp;
    e_rd   = (fault || we) ? 32'h0 : ld_exp(a);
    e_st   = 2 + rdy + (norsp ? TO : rsp + 1);
    @(negedge clk);
    i_lsu_wvalid = we;
    i_lsu_rvalid = !we;
    i_lsu_size   = sz;
    i_lsu_addr   = a;
    i_lsu_wdata  = wd;
    #1;
    if (is_mis(sz, a)) begin
      for (int i = 0; i < 3; i++) begin
        chk("mis_flag", o_misaligned, 1);
        chk("mis_stall", o_stall, 0);
        chk("mis_reqv", o_mem_req_valid, 0);
        @(negedge clk);
        #1;
      end
      i_lsu_wvalid = 0;
      i_lsu_rvalid = 0;
      return;
    end
    stalls = 0; rq = 0; rs = 0; cyc = 0; idx = 0;
    hs = 0; got = 0; fin = 0;
    while (!fin && cyc < 200) begin
      cyc++;
      chk("no_mis", o_misaligned, 0);
      if (o_stall) stalls++;
      else begin
        fin = 1;
        chk("rdata", o_lsu_rdata, e_rd);
        chk("fault", o_access_fault, 32'(fault));
        chk("stalls", stalls, e_st);
      end
      i_mem_req_ready = 0;
      i_mem_rsp_valid = 0;
      i_mem_rsp_err   = 0;
      i_mem_rsp_rdata = 0;
      if (o_mem_req_valid) begin
        chk("req_addr", o_mem_req_addr, {a[31:2], 2'b00});
        chk("req_we", o_mem_req_we, 32'(we));
        chk("req_strb", o_mem_req_wstrb, e_s);
        if (we) chk("req_wdata", o_mem_req_wdata, e_wd);
        if (rq == rdy) begin
          i_mem_req_ready = 1;
          hs     = 1;
          cap_a  = o_mem_req_addr;
          cap_wd = o_mem_req_wdata;
          cap_s  = o_mem_req_wstrb;
        end
        rq++;
      end else if (hs && !got && !fin) begin
        if (!norsp && rs == rsp) begin
          got = 1;
          idx = int'(cap_a[5:2]);
          i_mem_rsp_valid = 1;
          i_mem_rsp_err   = err;
          i_mem_rsp_rdata = we ? 32'h0 : dev[idx];
          if (we && !err)
            for (int b = 0; b < 4; b++)
              if (cap_s[b]) dev[idx][8*b +: 8] = cap_wd[8*b +: 8];
        end
        rs++;
      end
      if (fin) begin
        i_lsu_wvalid = 0;
        i_lsu_rvalid = 0;
      end
      @(negedge clk);
      #1;
    end
    if (!fin) chk("done_bound", 0, 1);
    i_mem_req_ready = 0;
    i_mem_rsp_valid = 0;
    i_mem_rsp_err   = 0;
    i_lsu_wvalid    = 0;
    i_lsu_rvalid    = 0;
    if (we && !fault)
      for (int i = 0; i < (1 << sz); i++)
        ref_b[int'(a[5:0]) + i] = wd[8*i +: 8];
  endtask

  int          cyc;
  logic [31:0] ca, cw;
  logic [3:0]  cs;

  initial begin
    i_rst = 1; i_lsu_wvalid = 0; i_lsu_rvalid = 0; i_lsu_size = 0;
    i_lsu_addr = 0; i_lsu_wdata = 0; i_mem_req_ready = 0;
    i_mem_rsp_valid = 0; i_mem_rsp_rdata = 0; i_mem_rsp_err = 0;
    for (int i = 0; i < 16; i++) begin
      dev[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*i + b] = dev[i][8*b +: 8];
    end
    @(negedge clk);
    #1;
    chk("rst_stall", o_stall, 0);
    chk("rst_mis", o_misaligned, 0);
    chk("rst_fault", o_access_fault, 0);
    chk("rst_rdata", o_lsu_rdata, 0);
    chk("rst_reqv", o_mem_req_valid, 0);
    chk("rst_we", o_mem_req_we, 0);
    chk("rst_addr", o_mem_req_addr, 0);
    chk("rst_wdata", o_mem_req_wdata, 0);
    chk("rst_strb", o_mem_req_wstrb, 0);
    repeat (2) @(negedge clk);
    i_rst = 0;

    access(1, 2'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, ca, cw, cs);
    chk("t1_strb", cs, 4'hF);
    chk("t1_wdata", cw, 32'hDEAD_BEEF);

    access(1, 2'd0, 32'h103, 32'h0000_00A5, 0, 0, 0, 0, ca, cw, cs);
    chk("t2_addr", ca, 32'h100);
    chk("t2_strb", cs, 4'h8);
    chk("t2_wdata", cw, 32'hA5A5_A5A5);

    access(1, 2'd2, 32'h200, 32'h1234_ABCD, 1, 1, 0, 0, ca, cw, cs);
    access(0, 2'd1, 32'h202, 32'h0, 5, 0, 0, 0, ca, cw, cs);
    chk("t3_ld", ld_exp(32'h202), 32'h0000_1234);

    access(0, 2'd2, 32'h301, 32'h0, 0, 0, 0, 0, ca, cw, cs);

    access(0, 2'd2, 32'h010, 32'h0, 0, 0, 0, 1, ca, cw, cs);
    access(0, 2'd2, 32'h014, 32'h0, 0, 1, 1, 0, ca, cw, cs);

    @(negedge clk);
    i_lsu_rvalid = 1; i_lsu_size = 2'd2; i_lsu_addr = 32'h24;
    #1;
    cyc = 0;
    while (!o_mem_req_valid && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("t6_reqv", o_mem_req_valid, 1);
    i_mem_req_ready = 1;
    @(negedge clk);
    #1;
    i_mem_req_ready = 0;
    chk("t6_resp_stall", o_stall, 1);
    i_rst = 1;
    i_lsu_rvalid = 0;
    #1;
    chk("t6_rst_stall", o_stall, 0);
    chk("t6_rst_addr", o_mem_req_addr, 0);
    chk("t6_rst_reqv", o_mem_req_valid, 0);
    @(negedge clk);
    i_rst = 0;
    i_mem_rsp_valid = 1;
    i_mem_rsp_rdata = 32'hFFFF_FFFF;
    i_mem_rsp_err = 1;
    @(negedge clk);
    #1;
    i_mem_rsp_valid = 0;
    i_mem_rsp_err = 0;
    chk("t6_stale_stall", o_stall, 0);
    chk("t6_stale_fault", o_access_fault, 0);
    chk("t6_stale_rdata", o_lsu_rdata, 0);
    chk("t6_stale_reqv", o_mem_req_valid, 0);
    access(0, 2'd2, 32'h024, 32'h0, 0, 0, 0, 0, ca, cw, cs);

    for (int n = 0; n < 80; n++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
             32'h400 | 32'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
             ca, cw, cs);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
